// File: rtl/glb_opsum_checker.sv
// glb_opsum_checker: walks a 3-D opsum region held in the GLB and
// compares every word against a streamed golden word under a mask.
module glb_opsum_checker #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_ch_num,
  input  logic [CNT_W-1:0]  cfg_row_num,
  input  logic [CNT_W-1:0]  cfg_col_num,
  input  logic [ADDR_W-1:0] cfg_ch_stride,
  input  logic [ADDR_W-1:0] cfg_row_stride,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic              glb_rd_en,
  output logic [ADDR_W-1:0] glb_addr,
  input  logic [DATA_W-1:0] glb_rdata,
  input  logic              gold_valid,
  input  logic [DATA_W-1:0] gold_data,
  output logic              gold_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_got,
  output logic [DATA_W-1:0] first_err_exp
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);
  localparam logic [2:0] WAIT_LAST = 3'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CMP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  ch_num;
  logic [CNT_W-1:0]  row_num;
  logic [CNT_W-1:0]  col_num;
  logic [ADDR_W-1:0] ch_stride;
  logic [ADDR_W-1:0] row_stride;
  logic [DATA_W-1:0] mask;

  logic [CNT_W-1:0]  ch;
  logic [CNT_W-1:0]  row;
  logic [CNT_W-1:0]  col;
  logic [ADDR_W-1:0] ch_addr;
  logic [ADDR_W-1:0] row_addr;
  logic [ADDR_W-1:0] addr;

  logic [2:0]        wait_cnt;
  logic [DATA_W-1:0] gold_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic accept;
  logic zero_dim;
  logic last_col;
  logic last_row;
  logic last_ch;
  logic last_elem;
  logic mism;
  logic wait_end;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign zero_dim = (cfg_ch_num == '0) || (cfg_row_num == '0) ||
                    (cfg_col_num == '0);
  assign last_col  = (col == col_num - CNT_W'(1));
  assign last_row  = (row == row_num - CNT_W'(1));
  assign last_ch   = (ch == ch_num - CNT_W'(1));
  assign last_elem = last_col && last_row && last_ch;
  assign mism      = |((rdata_reg ^ gold_reg) & mask);
  assign wait_end  = (wait_cnt == WAIT_LAST);

  assign glb_addr = addr;
  assign busy = (state == S_REQ) || (state == S_WAIT) || (state == S_CMP);
  assign done = (state == S_DONE);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // next state and handshake strobes
  always_comb begin
    state_nx   = state;
    glb_rd_en  = 1'b0;
    gold_ready = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nx = zero_dim ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (gold_valid) begin
          glb_rd_en  = 1'b1;
          gold_ready = 1'b1;
          state_nx   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_end) state_nx = S_CMP;
      end
      S_CMP: begin
        state_nx = last_elem ? S_DONE : S_REQ;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // config latch, walk counters, address generation and data capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      ch_num     <= '0;
      row_num    <= '0;
      col_num    <= '0;
      ch_stride  <= '0;
      row_stride <= '0;
      mask       <= '0;
      ch         <= '0;
      row        <= '0;
      col        <= '0;
      ch_addr    <= '0;
      row_addr   <= '0;
      addr       <= '0;
      wait_cnt   <= '0;
      gold_reg   <= '0;
      rdata_reg  <= '0;
    end else begin
      if (accept) begin
        ch_num     <= cfg_ch_num;
        row_num    <= cfg_row_num;
        col_num    <= cfg_col_num;
        ch_stride  <= cfg_ch_stride;
        row_stride <= cfg_row_stride;
        mask       <= cfg_mask;
        ch         <= '0;
        row        <= '0;
        col        <= '0;
        ch_addr    <= cfg_base_addr;
        row_addr   <= cfg_base_addr;
        addr       <= cfg_base_addr;
      end
      if (state == S_REQ && gold_valid) begin
        gold_reg <= gold_data;
        wait_cnt <= '0;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
      if (state == S_WAIT && wait_end) rdata_reg <= glb_rdata;
      if (state == S_CMP && !last_elem) begin
        if (!last_col) begin
          col  <= col + CNT_W'(1);
          addr <= addr + STEP;
        end else if (!last_row) begin
          col      <= '0;
          row      <= row + CNT_W'(1);
          row_addr <= row_addr + row_stride;
          addr     <= row_addr + row_stride;
        end else begin
          col      <= '0;
          row      <= '0;
          ch       <= ch + CNT_W'(1);
          ch_addr  <= ch_addr + ch_stride;
          row_addr <= ch_addr + ch_stride;
          addr     <= ch_addr + ch_stride;
        end
      end
    end
  end

  // mismatch count and first-mismatch capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
    end else if (accept) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
    end else if (state == S_CMP && mism) begin
      if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      if (err_cnt == '0) begin
        first_err_addr <= addr;
        first_err_got  <= rdata_reg;
        first_err_exp  <= gold_reg;
      end
    end
  end

endmodule

// File: tb/tb_glb_opsum_checker.sv
// tb_glb_opsum_checker: table-driven walks with a GLB model,
// a golden-stream driver and an address scoreboard.
module tb_glb_opsum_checker;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [CNT_W-1:0]  cfg_ch_num;
  logic [CNT_W-1:0]  cfg_row_num;
  logic [CNT_W-1:0]  cfg_col_num;
  logic [ADDR_W-1:0] cfg_ch_stride;
  logic [ADDR_W-1:0] cfg_row_stride;
  logic [DATA_W-1:0] cfg_mask;
  logic              glb_rd_en;
  logic [ADDR_W-1:0] glb_addr;
  logic [DATA_W-1:0] glb_rdata;
  logic              gold_valid;
  logic [DATA_W-1:0] gold_data;
  logic              gold_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_got;
  logic [DATA_W-1:0] first_err_exp;

  glb_opsum_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_ch_num    (cfg_ch_num),
    .cfg_row_num   (cfg_row_num),
    .cfg_col_num   (cfg_col_num),
    .cfg_ch_stride (cfg_ch_stride),
    .cfg_row_stride(cfg_row_stride),
    .cfg_mask      (cfg_mask),
    .glb_rd_en     (glb_rd_en),
    .glb_addr      (glb_addr),
    .glb_rdata     (glb_rdata),
    .gold_valid    (gold_valid),
    .gold_data     (gold_data),
    .gold_ready    (gold_ready),
    .busy          (busy),
    .done          (done),
    .err_cnt       (err_cnt),
    .first_err_addr(first_err_addr),
    .first_err_got (first_err_got),
    .first_err_exp (first_err_exp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [3:0]  chn;
    logic [3:0]  rown;
    logic [3:0]  coln;
    logic [15:0] chs;
    logic [15:0] rws;
    logic [31:0] mask;
    logic [31:0] flip;
    logic [31:0] bad;
    bit          rnd;
    bit          poke;
    int          exp_cyc;
    int          exp_err;
    logic [15:0] faddr;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int rd_cnt = 0;
  bit gold_rand = 1'b0;
  logic [31:0] mem [0:16383];
  logic [31:0] gold_q [$];
  logic [15:0] exp_q [$];
  logic [31:0] pipe [RD_LAT];
  vec_t vt [7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic [15:0] base, input logic [3:0] chn,
    input logic [3:0] rown, input logic [3:0] coln,
    input logic [15:0] chs, input logic [15:0] rws,
    input logic [31:0] mask, input logic [31:0] flip,
    input logic [31:0] bad, input bit rnd, input bit poke,
    input int exp_cyc, input int exp_err, input logic [15:0] faddr);
    vec_t v;
    v.name = nm; v.base = base; v.chn = chn; v.rown = rown;
    v.coln = coln; v.chs = chs; v.rws = rws; v.mask = mask;
    v.flip = flip; v.bad = bad; v.rnd = rnd; v.poke = poke;
    v.exp_cyc = exp_cyc; v.exp_err = exp_err; v.faddr = faddr;
    return v;
  endfunction

  // GLB model, golden-stream driver and read-address scoreboard
  initial begin
    logic        rd;
    logic        gh;
    logic [15:0] ra;
    gold_valid = 1'b0;
    gold_data  = '0;
    glb_rdata  = '0;
    for (int i = 0; i < RD_LAT; i++) pipe[i] = '0;
    forever begin
      @(negedge clk);
      rd = glb_rd_en;
      ra = glb_addr;
      gh = gold_valid && gold_ready;
      if (glb_rd_en || gold_ready)
        chk("strobe_pair", 32'(gold_ready), 32'(glb_rd_en));
      if (rd) begin
        rd_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read: got addr %0h expected no read", ra);
        end else begin
          chk("rd_addr", 32'(ra), 32'(exp_q.pop_front()));
        end
      end
      @(posedge clk);
      #1;
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = rd ? mem[ra[15:2]] : 32'h0;
      glb_rdata = pipe[RD_LAT-1];
      if (gh && gold_q.size() > 0) void'(gold_q.pop_front());
      gold_valid = (gold_q.size() > 0) &&
                   (!gold_rand || ($urandom_range(0, 1) == 1));
      gold_data = (gold_q.size() > 0) ? gold_q[0] : 32'h0;
    end
  end

  task automatic load_vec(input vec_t v, output logic [31:0] fgot,
                          output logic [31:0] fexp, output int total);
    logic [15:0] a;
    logic [31:0] g;
    int k;
    int fidx;
    exp_q.delete();
    gold_q.delete();
    fgot = '0;
    fexp = '0;
    fidx = -1;
    k = 0;
    for (int c = 0; c < int'(v.chn); c++)
      for (int r = 0; r < int'(v.rown); r++)
        for (int w = 0; w < int'(v.coln); w++) begin
          a = v.base + 16'(c) * v.chs + 16'(r) * v.rws + 16'(w * 4);
          g = $urandom;
          gold_q.push_back(g);
          exp_q.push_back(a);
          mem[a[15:2]] = v.bad[k] ? (g ^ v.flip) : g;
          if (v.exp_err > 0 && fidx < 0 && v.bad[k]) begin
            fidx = k;
            fgot = g ^ v.flip;
            fexp = g;
          end
          k++;
        end
    total = k;
    for (int i = 0; i < 3; i++) gold_q.push_back($urandom);
    gold_rand = v.rnd;
    rd_cnt = 0;
    cfg_base_addr  = v.base;
    cfg_ch_num     = v.chn;
    cfg_row_num    = v.rown;
    cfg_col_num    = v.coln;
    cfg_ch_stride  = v.chs;
    cfg_row_stride = v.rws;
    cfg_mask       = v.mask;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] fgot;
    logic [31:0] fexp;
    int total;
    int n;
    load_vec(v, fgot, fexp, total);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    if (total > 0) begin
      if (!v.rnd) chk({v.name, ".first_rd"}, 32'(glb_rd_en), 32'd1);
      chk({v.name, ".busy_on"}, 32'(busy), 32'd1);
      chk({v.name, ".done_clr"}, 32'(done), 32'd0);
    end
    while (!done && n < 3000) begin
      if (v.poke && n == 7) begin
        start = 1'b1;
        cfg_col_num = 4'd1;
        cfg_base_addr = 16'h3000;
        cfg_mask = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    chk({v.name, ".done"}, 32'(done), 32'd1);
    if (v.exp_cyc >= 0) chk({v.name, ".cycles"}, n, v.exp_cyc);
    chk({v.name, ".err_cnt"}, 32'(err_cnt), v.exp_err);
    chk({v.name, ".faddr"}, 32'(first_err_addr),
        (v.exp_err > 0) ? 32'(v.faddr) : 32'h0);
    chk({v.name, ".fgot"}, first_err_got, fgot);
    chk({v.name, ".fexp"}, first_err_exp, fexp);
    chk({v.name, ".reads"}, rd_cnt, total);
    chk({v.name, ".sb_left"}, exp_q.size(), 0);
    chk({v.name, ".gold_left"}, gold_q.size(), 3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk({v.name, ".done_hold"}, {30'd0, busy, done}, 32'd1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".busy"}, 32'(busy), 0);
    chk({nm, ".done"}, 32'(done), 0);
    chk({nm, ".rd_en"}, 32'(glb_rd_en), 0);
    chk({nm, ".ready"}, 32'(gold_ready), 0);
    chk({nm, ".addr"}, 32'(glb_addr), 0);
    chk({nm, ".err_cnt"}, 32'(err_cnt), 0);
    chk({nm, ".faddr"}, 32'(first_err_addr), 0);
    chk({nm, ".fgot"}, first_err_got, 0);
    chk({nm, ".fexp"}, first_err_exp, 0);
  endtask

  initial begin
    int t;
    rst = 1'b0;
    start = 1'b0;
    cfg_base_addr = '0;
    cfg_ch_num = '0;
    cfg_row_num = '0;
    cfg_col_num = '0;
    cfg_ch_stride = '0;
    cfg_row_stride = '0;
    cfg_mask = '0;

    vt[0] = mk("t1_clean", 16'h0100, 2, 2, 3, 16'h40, 16'h10,
               32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 36, 0, 16'h0);
    vt[1] = mk("t2_two_bad", 16'h0100, 2, 2, 3, 16'h40, 16'h10,
               32'hFFFF_FFFF, 32'h8000_0001, 32'h220, 0, 0, 36, 2,
               16'h0118);
    vt[2] = mk("t3_masked", 16'h0100, 2, 2, 3, 16'h40, 16'h10,
               32'h0000_FFFF, 32'hABCD_0000, 32'hFFF, 0, 0, 36, 0,
               16'h0);
    vt[3] = mk("t4_zero_col", 16'h0100, 2, 2, 0, 16'h40, 16'h10,
               32'hFFFF_FFFF, 32'h0, 32'h0, 0, 0, 0, 0, 16'h0);
    vt[4] = mk("wrap", 16'hFFF8, 2, 1, 4, 16'h8000, 16'h0,
               32'hFFFF_FFFF, 32'h0000_0100, 32'h8, 0, 0, 24, 1,
               16'h0004);
    vt[5] = mk("t6_saturate", 16'h0200, 1, 4, 5, 16'h0, 16'h14,
               32'hFFFF_FFFF, 32'h1, 32'hFFFFF, 0, 1, 60, 15,
               16'h0200);
    vt[6] = mk("t5_stall", 16'h0100, 2, 2, 3, 16'h40, 16'h10,
               32'hFFFF_FFFF, 32'h0000_0F00, 32'h220, 1, 0, -1, 2,
               16'h0118);

    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // reset in the middle of a stalled walk, after one mismatch
    begin
      logic [31:0] fgot;
      logic [31:0] fexp;
      int total;
      load_vec(vt[6], fgot, fexp, total);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t = 0;
      while (err_cnt == '0 && t < 2000) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("midrst.err_seen", 32'(err_cnt != '0), 1);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!glb_rd_en && t < 2000);
      @(posedge clk);
      #1;
      chk("midrst.in_wait", {30'd0, busy, glb_rd_en}, 32'd2);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_reset("midrst");
      gold_q.delete();
      exp_q.delete();
      rst = 1'b1;
      @(posedge clk);
      #1;
    end

    vt[0].rnd = 1'b1;
    vt[0].exp_cyc = -1;
    vt[0].name = "t5_restart";
    run_vec(vt[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
